// File: rtl/vacc_pkg.sv
// Shared constants and helpers for the vector-accumulator control path.
package vacc_pkg;

    // Pipeline latencies that make up the write-address sync realignment.
    localparam int unsigned QDR_LATENCY     = 10;
    localparam int unsigned ADD_LATENCY     = 5;
    localparam int unsigned VACC_SYNC_DELAY = 1 + QDR_LATENCY + ADD_LATENCY + 1;

    // Ceiling log2; clog2(0) and clog2(1) both return 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vacc_delay_pipe_ce_shift_reg.sv
// Clock-enabled WIDTH x DELAY shift-register delay line.
// ALLOW_SRL = "NO" tags the stages so synthesis keeps them as flip-flops.
module ce_shift_reg #(
    parameter int unsigned DELAY     = 1,
    parameter int unsigned WIDTH     = 1,
    parameter string       ALLOW_SRL = "YES"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DELAY == 0) begin : g_bypass
            // Zero-depth line: clock, reset and enable are intentionally unused.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, ce};
            assign dout        = din;
        end else if (ALLOW_SRL == "NO") begin : g_ff
            (* shreg_extract = "no" *) logic [WIDTH-1:0] stages [DELAY];

            // Shift one stage per enabled edge; reset clears every stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned k = 0; k < DELAY; k++) stages[k] <= '0;
                end else if (ce) begin
                    stages[0] <= din;
                    for (int unsigned k = 1; k < DELAY; k++) stages[k] <= stages[k-1];
                end
            end

            assign dout = stages[DELAY-1];
        end else begin : g_srl
            logic [WIDTH-1:0] stages [DELAY];

            // Shift one stage per enabled edge; reset clears every stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned k = 0; k < DELAY; k++) stages[k] <= '0;
                end else if (ce) begin
                    stages[0] <= din;
                    for (int unsigned k = 1; k < DELAY; k++) stages[k] <= stages[k-1];
                end
            end

            assign dout = stages[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/vacc_delay_pipe.sv
// Latency-matching block: data/flag delay line plus a counter-based
// single-pulse sync delay. Both paths advance only when ce is high.
module vacc_delay_pipe
    import vacc_pkg::*;
#(
    parameter int unsigned DELAY      = 1,
    parameter int unsigned WIDTH      = 1,
    parameter string       ALLOW_SRL  = "YES",
    parameter int unsigned SYNC_DELAY = VACC_SYNC_DELAY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             sync_in,
    output logic             sync_out
);

    ce_shift_reg #(
        .DELAY     (DELAY),
        .WIDTH     (WIDTH),
        .ALLOW_SRL (ALLOW_SRL)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .din  (din),
        .dout (dout)
    );

    generate
        if (SYNC_DELAY == 0) begin : g_sync_comb
            assign sync_out = sync_in;
        end else begin : g_sync_cnt
            localparam int unsigned CNT_W =
                (clog2(SYNC_DELAY + 1) > 0) ? clog2(SYNC_DELAY + 1) : 1;
            localparam logic [CNT_W-1:0] LOAD = CNT_W'(SYNC_DELAY - 1);

            logic [CNT_W-1:0] cnt;
            logic             busy;
            logic             pulse;
            logic             fire;

            // A one-cycle delay fires straight from the input; longer delays
            // fire on the enabled edge where the count reaches one.
            assign fire = (SYNC_DELAY == 1) ? sync_in : (busy && (cnt == CNT_W'(1)));

            // Restartable down-counter; the pulse register is loaded from fire
            // before the reload so a sync landing on the firing edge still
            // lets the old pulse out while arming a fresh count.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    pulse <= 1'b0;
                end else if (ce) begin
                    pulse <= fire;
                    if (sync_in && (SYNC_DELAY > 1)) begin
                        cnt  <= LOAD;
                        busy <= 1'b1;
                    end else if (busy) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) busy <= 1'b0;
                    end
                end
            end

            assign sync_out = pulse;
        end
    endgenerate

endmodule

// File: tb/tb_vacc_delay_pipe.sv
// Self-checking bench for vacc_delay_pipe against a history-based model.
module tb_vacc_delay_pipe;

    localparam int DLY = 4;
    localparam int SD  = 17;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b0;
    logic       sync_in = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout_a, dout_b, dout_c;
    logic       sync_a, sync_b, sync_c;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: inputs seen on each enabled edge since the last reset.
    logic [7:0] din_h[$];
    logic       sy_h[$];

    always #5 clk = ~clk;

    vacc_delay_pipe #(.DELAY(DLY), .WIDTH(8), .ALLOW_SRL("YES"), .SYNC_DELAY(SD)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .din(din), .dout(dout_a), .sync_in(sync_in), .sync_out(sync_a));

    vacc_delay_pipe #(.DELAY(DLY), .WIDTH(8), .ALLOW_SRL("NO"), .SYNC_DELAY(SD)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .din(din), .dout(dout_b), .sync_in(sync_in), .sync_out(sync_b));

    vacc_delay_pipe #(.DELAY(0), .WIDTH(8), .ALLOW_SRL("YES"), .SYNC_DELAY(0)) dut_c (
        .clk(clk), .rst(rst), .ce(ce), .din(din), .dout(dout_c), .sync_in(sync_in), .sync_out(sync_c));

    // dout shows the value sampled DLY enabled edges ago, zero before that.
    function automatic logic [7:0] exp_dout();
        int e = din_h.size();
        return (e >= DLY) ? din_h[e-DLY] : 8'h00;
    endfunction

    // sync_out is high after enabled edge m iff a sync was sampled at m-SD+1
    // and no sync in between restarted the count.
    function automatic logic exp_sync();
        int e = sy_h.size();
        int n = e - SD;
        if (n < 0) return 1'b0;
        if (!sy_h[n]) return 1'b0;
        for (int k = n + 1; k < e - 1; k++) if (sy_h[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst && ce) begin
            din_h.push_back(din);
            sy_h.push_back(sync_in);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        din_h.delete();
        sy_h.delete();
    endtask

    // Drives a sync pattern with ce high; records up to two pulse cycles.
    task automatic run_sync(input int a, input int a_len, input int b, input int cycles,
                            output int cnt, output int p0, output int p1);
        cnt = 0; p0 = -1; p1 = -1;
        ce = 1'b1;
        for (int t = 0; t < cycles; t++) begin
            din     = 8'($urandom_range(1, 255));
            sync_in = ((t >= a) && (t < a + a_len)) || (t == b);
            step();
            n_checks++;
            if (sync_a !== exp_sync() || sync_b !== exp_sync()) begin
                n_fail++;
                $display("FAIL sync_cycle t=%0d: sync_a=%b sync_b=%b required %b", t, sync_a, sync_b, exp_sync());
            end
            n_checks++;
            if (dout_a !== exp_dout() || dout_b !== exp_dout()) begin
                n_fail++;
                $display("FAIL dout_cycle t=%0d: dout_a=%h dout_b=%h required %h", t, dout_a, dout_b, exp_dout());
            end
            if (sync_a) begin
                if (cnt == 0) p0 = t;
                else if (cnt == 1) p1 = t;
                cnt++;
            end
        end
        sync_in = 1'b0;
    endtask

    task automatic test_reset();
        ce = 1'b1; din = 8'h5A; sync_in = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (dout_a !== 8'h00 || dout_b !== 8'h00 || sync_a !== 1'b0 || sync_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: dout_a=%h dout_b=%h sync_a=%b sync_b=%b required 00 00 0 0", dout_a, dout_b, sync_a, sync_b);
        end
        step(); step();
        n_checks++;
        if (dout_a !== 8'h00 || dout_b !== 8'h00 || sync_a !== 1'b0 || sync_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_over_ce: dout_a=%h dout_b=%h sync_a=%b sync_b=%b required 00 00 0 0", dout_a, dout_b, sync_a, sync_b);
        end
        sync_in = 1'b0;
        rst = 1'b0;
        din_h.delete();
        sy_h.delete();
    endtask

    task automatic test_delay_seq();
        apply_reset();
        ce = 1'b1; sync_in = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            din = (i <= 16) ? 8'(i) : 8'h00;
            step();
            n_checks++;
            if (dout_a !== exp_dout() || dout_b !== exp_dout()) begin
                n_fail++;
                $display("FAIL delay_seq i=%0d: dout_a=%h dout_b=%h required %h", i, dout_a, dout_b, exp_dout());
            end
            if (i == 3 || i == 4) begin
                n_checks++;
                if (dout_a !== ((i == 4) ? 8'h01 : 8'h00)) begin
                    n_fail++;
                    $display("FAIL delay_first i=%0d: dout_a=%h required %h", i, dout_a, (i == 4) ? 8'h01 : 8'h00);
                end
            end
        end
    endtask

    task automatic test_ce_toggle();
        apply_reset();
        sync_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ce  = (i % 2 == 0);
            din = 8'(i / 2 + 1);
            step();
            n_checks++;
            if (dout_a !== exp_dout() || dout_b !== exp_dout()) begin
                n_fail++;
                $display("FAIL ce_toggle i=%0d: dout_a=%h dout_b=%h required %h", i, dout_a, dout_b, exp_dout());
            end
            if (i == 5 || i == 6) begin
                n_checks++;
                if (dout_a !== ((i == 6) ? 8'h01 : 8'h00)) begin
                    n_fail++;
                    $display("FAIL ce_first i=%0d: dout_a=%h required %h", i, dout_a, (i == 6) ? 8'h01 : 8'h00);
                end
            end
        end
        ce = 1'b1;
    endtask

    task automatic test_sync_patterns();
        int cnt, p0, p1;
        // Isolated pulse.
        apply_reset();
        run_sync(10, 1, -1, 40, cnt, p0, p1);
        n_checks++;
        if (cnt != 1 || p0 != 10 + SD - 1) begin
            n_fail++;
            $display("FAIL sync_isolated: pulses=%0d at %0d required 1 at %0d", cnt, p0, 10 + SD - 1);
        end
        // Restart: second sync abandons the first count.
        apply_reset();
        run_sync(10, 1, 15, 45, cnt, p0, p1);
        n_checks++;
        if (cnt != 1 || p0 != 15 + SD - 1) begin
            n_fail++;
            $display("FAIL sync_restart: pulses=%0d at %0d required 1 at %0d", cnt, p0, 15 + SD - 1);
        end
        // Sync on the firing cycle: both pulses appear.
        apply_reset();
        run_sync(10, 1, 10 + SD - 1, 55, cnt, p0, p1);
        n_checks++;
        if (cnt != 2 || p0 != 10 + SD - 1 || p1 != 10 + 2 * (SD - 1)) begin
            n_fail++;
            $display("FAIL sync_refire: pulses=%0d at %0d,%0d required 2 at %0d,%0d",
                     cnt, p0, p1, 10 + SD - 1, 10 + 2 * (SD - 1));
        end
        // Held sync: one pulse after the last high cycle.
        apply_reset();
        run_sync(10, 5, -1, 45, cnt, p0, p1);
        n_checks++;
        if (cnt != 1 || p0 != 14 + SD - 1) begin
            n_fail++;
            $display("FAIL sync_held: pulses=%0d at %0d required 1 at %0d", cnt, p0, 14 + SD - 1);
        end
    endtask

    task automatic test_async_reset();
        int cnt, p0, p1;
        apply_reset();
        run_sync(10, 1, -1, 20, cnt, p0, p1);
        din = 8'hA5;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (dout_a !== 8'h00 || dout_b !== 8'h00 || sync_a !== 1'b0 || sync_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: dout_a=%h dout_b=%h sync_a=%b sync_b=%b required 00 00 0 0", dout_a, dout_b, sync_a, sync_b);
        end
        #1 rst = 1'b0;
        din_h.delete();
        sy_h.delete();
        run_sync(-1, 0, -1, 30, cnt, p0, p1);
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL reset_cancel: pulses=%0d required 0", cnt);
        end
    endtask

    task automatic test_comb_and_hold();
        logic [7:0] held_d;
        logic       held_s;
        ce = 1'b0;
        held_d = dout_a;
        held_s = sync_a;
        for (int i = 0; i < 20; i++) begin
            din     = 8'($urandom);
            sync_in = 1'($urandom);
            #1;
            n_checks++;
            if (dout_c !== din || sync_c !== sync_in) begin
                n_fail++;
                $display("FAIL comb_path i=%0d: dout_c=%h sync_c=%b required %h %b", i, dout_c, sync_c, din, sync_in);
            end
            n_checks++;
            if (dout_a !== held_d || sync_a !== held_s) begin
                n_fail++;
                $display("FAIL ce_hold i=%0d: dout_a=%h sync_a=%b required %h %b", i, dout_a, sync_a, held_d, held_s);
            end
        end
        @(negedge clk);
        sync_in = 1'b0;
        ce = 1'b1;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            ce      = ($urandom_range(0, 3) != 0);
            din     = 8'($urandom);
            sync_in = ($urandom_range(0, 19) == 0);
            step();
            n_checks++;
            if (dout_a !== exp_dout() || dout_b !== exp_dout() || dout_c !== din) begin
                n_fail++;
                $display("FAIL rand_dout i=%0d: dout_a=%h dout_b=%h dout_c=%h required %h %h", i, dout_a, dout_b, dout_c, exp_dout(), din);
            end
            n_checks++;
            if (sync_a !== exp_sync() || sync_b !== exp_sync() || sync_c !== sync_in) begin
                n_fail++;
                $display("FAIL rand_sync i=%0d: sync_a=%b sync_b=%b sync_c=%b required %b %b", i, sync_a, sync_b, sync_c, exp_sync(), sync_in);
            end
        end
    endtask

    initial begin
        test_reset();
        test_delay_seq();
        test_ce_toggle();
        test_sync_patterns();
        test_async_reset();
        test_comb_and_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
